// File: rtl/rsnn_readout_pkg.sv
// Shared types, default widths and saturation helper for the RSNN spike readout.
package rsnn_readout_pkg;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DRAIN = 1'b1
  } readout_state_e;

  localparam int DEF_NUM_NEURONS = 3;
  localparam int DEF_CNT_W       = 4;
  localparam int DEF_WIN_W       = 4;
  localparam int DEF_IDX_W       = 2;

  function automatic logic [31:0] sat_max(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/rsnn_spike_readout_if.sv
// Readout stream: one neuron count per valid/ready transfer.
interface rsnn_spike_readout_if
  import rsnn_readout_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int IDX_W = DEF_IDX_W
);

  logic [CNT_W-1:0] out_count;
  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_count, output out_idx, output out_valid, input out_ready);
  modport slave  (input out_count, input out_idx, input out_valid, output out_ready);

endinterface

// File: rtl/rsnn_sat_counter.sv
// Saturating spike counter; snap is the pre-clear count plus this cycle's increment.
module rsnn_sat_counter
  import rsnn_readout_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] snap
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(sat_max(CNT_W));

  logic [CNT_W-1:0] count_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic i);
    return (i && (c != MAX_CNT)) ? c + 1'b1 : c;
  endfunction

  assign snap = sat_inc(count_p0, inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count_p0 <= '0;
    else if (clr) count_p0 <= '0;
    else          count_p0 <= snap;
  end

endmodule

// File: rtl/rsnn_spike_readout.sv
// Windowed per-neuron spike counting with shadow snapshot streamed over valid/ready.
// Optional argmax winner register enabled by defining RSNN_READOUT_ARGMAX_EN.
module rsnn_spike_readout
  import rsnn_readout_pkg::*;
#(
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int WIN_W       = DEF_WIN_W,
  parameter int IDX_W       = DEF_IDX_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [NUM_NEURONS-1:0] spikes_in,
  input  logic                   spikes_valid,
  input  logic [WIN_W-1:0]       window_len,
  rsnn_spike_readout_if.master   out_if,
  output logic                   window_done,
  output logic                   overrun,
  output logic [IDX_W-1:0]       winner_idx
);

  localparam logic [0:0]       ACCUM    = ST_ACCUM;
  localparam logic [0:0]       DRAIN    = ST_DRAIN;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  logic [0:0]       state;
  logic [WIN_W-1:0] step_p0;
  logic [WIN_W-1:0] win_len_q;
  logic [WIN_W-1:0] eff_len;
  logic [WIN_W-1:0] last_step;
  logic             accept;
  logic             win_end;
  logic             snap_take;

  logic [CNT_W-1:0] snap_p0   [NUM_NEURONS];
  logic [CNT_W-1:0] shadow_p1 [NUM_NEURONS];
  logic [IDX_W-1:0] out_idx_p1;
  logic [CNT_W-1:0] out_count_p1;
  logic             vld_p1;

  assign accept    = enable & spikes_valid;
  // At step 0 the incoming window_len applies directly, so a 1-step window ends immediately.
  assign eff_len   = (step_p0 == '0) ? window_len : win_len_q;
  // Wraps to all-ones when eff_len is 0, giving the 2^WIN_W-step window.
  assign last_step = eff_len - 1'b1;
  assign win_end   = accept && (step_p0 == last_step);
  assign snap_take = win_end && (state == ACCUM);

  // ---- stage p0: live accumulation ----
  for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_cnt
    rsnn_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (accept & spikes_in[i]),
      .clr   (win_end),
      .snap  (snap_p0[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_p0   <= '0;
      win_len_q <= '0;
    end else begin
      if (step_p0 == '0) win_len_q <= window_len;
      if (accept)        step_p0   <= win_end ? '0 : step_p0 + 1'b1;
    end
  end

  // ---- stage p1: shadow snapshot and drain ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) shadow_p1[i] <= '0;
    end else if (snap_take) begin
      for (int i = 0; i < NUM_NEURONS; i++) shadow_p1[i] <= snap_p0[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACCUM;
      vld_p1      <= 1'b0;
      out_idx_p1  <= '0;
      window_done <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      window_done <= snap_take;
      if (win_end && (state == DRAIN)) overrun <= 1'b1;
      case (state)
        ACCUM: begin
          if (snap_take) begin
            state      <= DRAIN;
            vld_p1     <= 1'b1;
            out_idx_p1 <= '0;
          end
        end
        DRAIN: begin
          if (vld_p1 && out_if.out_ready) begin
            if (out_idx_p1 == LAST_IDX) begin
              state      <= ACCUM;
              vld_p1     <= 1'b0;
              out_idx_p1 <= '0;
            end else begin
              out_idx_p1 <= out_idx_p1 + 1'b1;
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  always_comb begin
    out_count_p1 = '0;
    if (vld_p1) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (out_idx_p1 == IDX_W'(i)) out_count_p1 = shadow_p1[i];
      end
    end
  end

  assign out_if.out_count = out_count_p1;
  assign out_if.out_idx   = out_idx_p1;
  assign out_if.out_valid = vld_p1;

`ifdef RSNN_READOUT_ARGMAX_EN
  logic [IDX_W-1:0] best_idx;
  logic [CNT_W-1:0] best_cnt;

  // Strict greater-than keeps the lowest index on ties and yields 0 for all-zero counts.
  always_comb begin
    best_idx = '0;
    best_cnt = snap_p0[0];
    for (int i = 1; i < NUM_NEURONS; i++) begin
      if (snap_p0[i] > best_cnt) begin
        best_cnt = snap_p0[i];
        best_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         winner_idx <= '0;
    else if (snap_take) winner_idx <= best_idx;
  end
`else
  assign winner_idx = '0;
`endif

endmodule

// File: tb/tb_rsnn_spike_readout.sv
// Scoreboard bench for rsnn_spike_readout: window-level reference model feeds an expected-transfer queue.
module tb_rsnn_spike_readout;

  localparam int N  = 3;
  localparam int CW = 4;
  localparam int WW = 4;
  localparam int IW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          spikes_valid = 1'b0;
  logic [N-1:0]  spikes_in = '0;
  logic [WW-1:0] window_len = '0;
  logic          window_done;
  logic          overrun;
  logic [IW-1:0] winner_idx;

  rsnn_spike_readout_if #(.CNT_W(CW), .IDX_W(IW)) oif ();

  rsnn_spike_readout #(.NUM_NEURONS(N), .CNT_W(CW), .WIN_W(WW), .IDX_W(IW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .spikes_in    (spikes_in),
    .spikes_valid (spikes_valid),
    .window_len   (window_len),
    .out_if       (oif),
    .window_done  (window_done),
    .overrun      (overrun),
    .winner_idx   (winner_idx)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int idx;
    int cnt;
  } xfer_t;
  xfer_t exp_q[$];

  int m_live[N];
  int m_step;
  int m_wl_q;
  int m_out;
  int m_win;
  bit m_wd;
  bit m_ovr;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_live[i] = 0;
    m_step = 0; m_wl_q = 0; m_out = 0; m_win = 0; m_wd = 0; m_ovr = 0;
    exp_q.delete();
  endtask

  // Reference model: counts per window, decides whether a finished window is streamed or dropped.
  task automatic model_step();
    int  wl;
    int  len;
    bit  draining;
    xfer_t x;
    draining = (m_out > 0);
    m_wd = 0;
    wl = (m_step == 0) ? int'(window_len) : m_wl_q;
    if (m_step == 0) m_wl_q = int'(window_len);
    if (draining && oif.out_ready) m_out--;
    if (enable && spikes_valid) begin
      len = (wl == 0) ? (1 << WW) : wl;
      for (int i = 0; i < N; i++)
        if (spikes_in[i] && m_live[i] < CMAX) m_live[i]++;
      m_step++;
      if (m_step == len) begin
        if (draining) begin
          m_ovr = 1;
        end else begin
          for (int i = 0; i < N; i++) begin
            x.idx = i; x.cnt = m_live[i];
            exp_q.push_back(x);
          end
          m_out = N;
          m_wd  = 1;
`ifdef RSNN_READOUT_ARGMAX_EN
          m_win = 0;
          for (int i = 1; i < N; i++) if (m_live[i] > m_live[m_win]) m_win = i;
`endif
        end
        for (int i = 0; i < N; i++) m_live[i] = 0;
        m_step = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Monitor: compares the stream and status outputs on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("out_valid", int'(oif.out_valid), int'(m_out > 0));
        chk("window_done", int'(window_done), int'(m_wd));
        chk("overrun", int'(overrun), int'(m_ovr));
        chk("winner_idx", int'(winner_idx), m_win);
        if (oif.out_valid) begin
          if (exp_q.size() == 0) begin
            chk("xfer_expected", exp_q.size(), 1);
          end else begin
            chk("out_idx", int'(oif.out_idx), exp_q[0].idx);
            chk("out_count", int'(oif.out_count), exp_q[0].cnt);
            if (oif.out_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic drive(input bit en, input bit sv, input logic [N-1:0] sp, input int wl, input bit rdy);
    enable        = en;
    spikes_valid  = sv;
    spikes_in     = sp;
    window_len    = WW'(wl);
    oif.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input int wl);
    repeat (n) drive(1'b1, 1'b0, '0, wl, 1'b1);
  endtask

  initial begin
    logic [N-1:0] argmax_pat [5];
    argmax_pat[0] = 3'b111; argmax_pat[1] = 3'b111; argmax_pat[2] = 3'b111;
    argmax_pat[3] = 3'b110; argmax_pat[4] = 3'b110;
    oif.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(oif.out_valid), 0);
    chk("rst_out_count", int'(oif.out_count), 0);
    chk("rst_window_done", int'(window_done), 0);
    rst_n = 1'b1;

    // Basic window of 4 with pattern 101
    repeat (4) drive(1'b1, 1'b1, 3'b101, 4, 1'b1);
    idle(5, 4);

    // 16-step window, saturation
    repeat (16) drive(1'b1, 1'b1, 3'b111, 0, 1'b1);
    idle(5, 0);

    // Backpressure while the next window keeps accumulating
    repeat (3) drive(1'b1, 1'b1, N'($urandom), 3, 1'b0);
    repeat (10) drive(1'b1, 1'b1, N'($urandom), 0, 1'b0);
    repeat (6) drive(1'b1, 1'b1, N'($urandom), 0, 1'b1);
    idle(5, 0);

    // Argmax patterns: (3,5,5) then all zero
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, argmax_pat[i], 5, 1'b1);
    idle(4, 2);
    repeat (2) drive(1'b1, 1'b1, 3'b000, 2, 1'b1);
    idle(4, 2);

    // Overrun: 1-step windows while the consumer stalls
    repeat (4) drive(1'b1, 1'b1, 3'b010, 1, 1'b0);
    idle(5, 1);

    // Asynchronous reset in the middle of a drain
    repeat (2) drive(1'b1, 1'b1, 3'b111, 2, 1'b0);
    drive(1'b1, 1'b0, '0, 2, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", int'(oif.out_valid), 0);
    chk("async_rst_out_count", int'(oif.out_count), 0);
    chk("async_rst_out_idx", int'(oif.out_idx), 0);
    chk("async_rst_window_done", int'(window_done), 0);
    chk("async_rst_overrun", int'(overrun), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) drive(1'b1, 1'b1, 3'b011, 3, 1'b1);
    idle(5, 3);

    // Randomized traffic: enable gaps, idle steps, mid-window length changes, random backpressure
    repeat (400)
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, N'($urandom),
            int'($urandom_range(0, 6)), $urandom_range(0, 3) != 0);

    repeat (20) drive(1'b0, 1'b0, '0, 0, 1'b1);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rsnn_spike_readout.md
Name: rsnn_spike_readout

Overview:
- Downstream of the RSNN top module. Consumes its per-timestep output spike vector and counts spikes per output neuron over a programmable window of timesteps.
- At each window end, snapshots the counts into a shadow buffer and streams them out one neuron per transfer over a valid/ready handshake.
- Provides the rate-coded result readout for the tile's output pins or host logic.

Parameters:
- NUM_NEURONS, 3, number of output neurons (width of spike vector).
- CNT_W, 4, per-neuron spike counter width (saturating).
- WIN_W, 4, width of window_len.
- IDX_W, 2, width of neuron index on output, >= clog2(NUM_NEURONS).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  accumulation enable; low freezes step counter and live counters.
- spikes_in  input  NUM_NEURONS  output_spikes from the RSNN.
- spikes_valid  input  1  spikes_in holds a new timestep this cycle.
- window_len  input  WIN_W  timesteps per window; 0 means 2^WIN_W.
- out_count  output  CNT_W  spike count of neuron out_idx.
- out_idx  output  IDX_W  neuron index of current transfer.
- out_valid  output  1  out_count/out_idx valid.
- out_ready  input  1  consumer accepts the transfer.
- window_done  output  1  one-cycle pulse: snapshot taken.
- overrun  output  1  sticky: a window completed while the previous one was still draining.
- winner_idx  output  IDX_W  argmax of the last snapshot (see Optional Feature).

Behaviour:
- Reset (async, immediate): all outputs 0. Live counters, shadow counters, step counter, out_idx and winner_idx cleared. State = ACCUM.
- Timestep accepted when enable & spikes_valid. For each set bit i, live[i] increments, saturating at 2^CNT_W-1. Step counter increments.
- window_len is latched into win_len_q when the step counter is 0; changes mid-window are ignored.
- Last step of a window (step == win_len_q-1, with 0 meaning 2^WIN_W):
  - The shadow buffer receives the counts including this step's spikes.
  - Live counters and step counter clear on the same edge.
  - window_done pulses on the next cycle.
- FSM: ACCUM and DRAIN.
  - ACCUM -> DRAIN on the snapshot edge. out_valid=1 and out_idx=0 from the next cycle.
  - DRAIN: out_count = shadow[out_idx]. On out_valid & out_ready, out_idx advances.
  - After the transfer with out_idx == NUM_NEURONS-1: out_valid=0, out_idx=0, next state ACCUM.
  - Transfer latency from snapshot is 1 cycle. Throughput is 1 neuron per cycle with out_ready held high.
- Accumulation continues during DRAIN (live counters are double-buffered against shadow).
- Window end while in DRAIN:
  - Shadow is not overwritten and the completed window's counts are dropped.
  - Live counters and step counter still clear, and window_done does not pulse.
  - overrun sets and stays set until reset.
- While out_valid=1 and out_ready=0, out_count and out_idx hold stable.
- enable low: no accumulation and no step advance. The DRAIN handshake is unaffected.
- spikes_valid with enable low is discarded.

Optional Feature:
- Macro: RSNN_READOUT_ARGMAX_EN.
- Defined: on each snapshot edge, winner_idx is registered as the index of the maximum shadow count; ties resolve to the lowest index; all-zero gives 0. winner_idx is valid from the window_done cycle and held until the next snapshot.
- Undefined: winner_idx is tied to 0 and no compare logic is built.

Decomposition:
- Package rsnn_readout_pkg: state enum (ACCUM, DRAIN), default widths CNT_W, WIN_W, IDX_W, and a saturation max-value function.
- One natural sub-module, rsnn_sat_counter: a CNT_W saturating counter with inc and clr inputs, where clr wins over inc but the snapshot uses the pre-clear value plus inc. It is instantiated NUM_NEURONS times.

Test Plan:
- window_len=4; spikes_in=3'b101 valid for 4 steps; out_ready=1 -> window_done pulse. Stream: (idx0,4), (idx1,0), (idx2,4) on consecutive cycles; overrun=0.
- window_len=0 (16 steps); spikes_in=3'b111 for 16 steps -> all counts 15 (saturated, not wrapped); window_done after the 16th step.
- Backpressure: snapshot, then out_ready=0 for 10 cycles -> out_valid=1, out_idx=0 and out_count stable throughout. Live counters keep accumulating; on release the stream finishes in 3 cycles.
- Overrun: window_len=1, spikes 3'b010 every cycle, out_ready=0 -> second window end during DRAIN sets overrun=1. The drained data still reads (0,1,0).
- Reset: assert rst_n low mid-DRAIN, asynchronously between clock edges -> out_valid, out_count, out_idx and window_done read 0 immediately. After release, the first window counts from 0.
- With RSNN_READOUT_ARGMAX_EN: counts (3,5,5) give winner_idx=1; counts (0,0,0) give 0. Without the macro, winner_idx stays 0.
